// File: rtl/p405s_dcu_fb_pkg.sv
// Shared types and helpers for the DCU line fill buffer.
// Holds the fill/drain state encoding, default geometry and the byte-lane
// position helper (byte 0 is the most significant byte of a word).
package p405s_dcu_fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fbState_e;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_WORD_W         = 32;
  localparam int DEF_BYTES          = DEF_WORD_W / 8;
  localparam int DEF_SEL_W          = $clog2(DEF_WORDS_PER_LINE);

  // Bit position of the least significant bit of byte lane 'lane'.
  // Lane 0 sits at the top of the word (big-endian lane numbering).
  function automatic int laneLsb(input int lane, input int bytes);
    return (bytes - 1 - lane) * 8;
  endfunction

endpackage

// File: rtl/p405s_dcu_fb_byte_merge.sv
// Per-word byte merge for the fill buffer.
// Store bytes always win; fill data only lands in bytes that no store has
// claimed yet, so a late-arriving fill never overwrites newer store data.
module p405s_dcu_fb_byte_merge
  import p405s_dcu_fb_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BYTES  = WORD_W / 8
) (
  input  logic [WORD_W-1:0] curWord,
  input  logic [BYTES-1:0]  ownedMask,
  input  logic              fillWe,
  input  logic [WORD_W-1:0] fillData,
  input  logic              storeWe,
  input  logic [BYTES-1:0]  storeByteEn,
  input  logic [WORD_W-1:0] storeData,
  output logic [WORD_W-1:0] nextWord,
  output logic [BYTES-1:0]  nextOwned
);

  // Select each byte lane from store, fill or the held value.
  always_comb begin
    nextWord  = curWord;
    nextOwned = ownedMask;
    for (int b = 0; b < BYTES; b++) begin
      if (storeWe && storeByteEn[b]) begin
        nextWord[laneLsb(b, BYTES) +: 8] = storeData[laneLsb(b, BYTES) +: 8];
        nextOwned[b]                     = 1'b1;
      end else if (fillWe && !ownedMask[b]) begin
        nextWord[laneLsb(b, BYTES) +: 8] = fillData[laneLsb(b, BYTES) +: 8];
      end else begin
        nextWord[laneLsb(b, BYTES) +: 8] = curWord[laneLsb(b, BYTES) +: 8];
      end
    end
  end

endmodule

// File: rtl/p405s_dcu_fill_buffer.sv
// DCU line fill buffer: critical-word-first fill tracking, sticky store-byte
// ownership, one-cycle load bypass and in-order drain to the cache array.
// Optional build macro: P405S_DCU_FB_STORE_FWD_EN -- when defined, the bypass
// result also reflects fill/store writes accepted in the request cycle.
module p405s_dcu_fill_buffer
  import p405s_dcu_fb_pkg::*;
#(
  parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int WORD_W         = DEF_WORD_W,
  localparam int BYTES          = WORD_W / 8,
  localparam int SEL_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic              CB,
  input  logic              reset,
  input  logic              fillStart,
  input  logic [SEL_W-1:0]  fillCritWord,
  input  logic              fillDataVal,
  input  logic [WORD_W-1:0] fillData,
  input  logic              storeVal,
  input  logic [SEL_W-1:0]  storeWord,
  input  logic [BYTES-1:0]  storeByteEn,
  input  logic [WORD_W-1:0] storeData,
  output logic              storeAck,
  input  logic              bypassReq,
  input  logic [SEL_W-1:0]  bypassWord,
  output logic              bypassHit,
  output logic [WORD_W-1:0] bypassData,
  output logic              drainVal,
  input  logic              drainRdy,
  output logic [SEL_W-1:0]  drainWordIdx,
  output logic [WORD_W-1:0] drainData,
  output logic              busy
);

  fbState_e                state_r;
  logic [SEL_W-1:0]        fillPtr_r;
  logic [SEL_W-1:0]        fillCnt_r;
  logic [SEL_W-1:0]        drainIdx_r;
  logic                    bypassHit_r;
  logic [WORD_W-1:0]       bypassData_r;
  logic [WORD_W-1:0]       words_r     [WORDS_PER_LINE];
  logic [BYTES-1:0]        owned_r     [WORDS_PER_LINE];
  logic [WORDS_PER_LINE-1:0] fillVld_r;

  logic [WORD_W-1:0]       mergedWord_s  [WORDS_PER_LINE];
  logic [BYTES-1:0]        mergedOwned_s [WORDS_PER_LINE];
  logic [WORDS_PER_LINE-1:0] fillWe_s;
  logic [WORDS_PER_LINE-1:0] storeWe_s;
  logic [WORDS_PER_LINE-1:0] wordVld_s;

  logic fillAcc_s, storeAcc_s, drainAcc_s, fillLast_s, drainLast_s, lineStart_s;
  logic              bypHitNext_s;
  logic [WORD_W-1:0] bypDataNext_s;

  assign fillAcc_s   = (state_r == FILL) && fillDataVal;
  assign storeAcc_s  = (state_r == FILL) && storeVal;
  assign drainAcc_s  = (state_r == DRAIN) && drainRdy;
  assign fillLast_s  = fillAcc_s && (fillCnt_r == SEL_W'(WORDS_PER_LINE - 1));
  assign drainLast_s = drainAcc_s && (drainIdx_r == SEL_W'(WORDS_PER_LINE - 1));
  // A new line may start from IDLE or on the final drain handshake.
  assign lineStart_s = fillStart && ((state_r == IDLE) || drainLast_s);

  for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : gWord
    assign fillWe_s[w]  = fillAcc_s && (fillPtr_r == SEL_W'(w));
    assign storeWe_s[w] = storeAcc_s && (storeWord == SEL_W'(w));
    assign wordVld_s[w] = fillVld_r[w] || (&owned_r[w]);

    p405s_dcu_fb_byte_merge #(
      .WORD_W (WORD_W),
      .BYTES  (BYTES)
    ) uMerge (
      .curWord     (words_r[w]),
      .ownedMask   (owned_r[w]),
      .fillWe      (fillWe_s[w]),
      .fillData    (fillData),
      .storeWe     (storeWe_s[w]),
      .storeByteEn (storeByteEn),
      .storeData   (storeData),
      .nextWord    (mergedWord_s[w]),
      .nextOwned   (mergedOwned_s[w])
    );
  end

`ifdef P405S_DCU_FB_STORE_FWD_EN
  logic [WORDS_PER_LINE-1:0] wordVldNext_s;

  for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : gVldNext
    assign wordVldNext_s[w] = fillVld_r[w] || fillWe_s[w] || (&mergedOwned_s[w]);
  end

  // Bypass lookup against the buffer including this cycle's writes.
  always_comb begin
    bypHitNext_s  = 1'b0;
    bypDataNext_s = {WORD_W{1'b0}};
    if (bypassReq && (state_r != IDLE) && wordVldNext_s[bypassWord]) begin
      bypHitNext_s  = 1'b1;
      bypDataNext_s = mergedWord_s[bypassWord];
    end else begin
      bypHitNext_s  = 1'b0;
      bypDataNext_s = {WORD_W{1'b0}};
    end
  end
`else
  // Bypass lookup against the buffer as it stood at the start of the cycle.
  always_comb begin
    bypHitNext_s  = 1'b0;
    bypDataNext_s = {WORD_W{1'b0}};
    if (bypassReq && (state_r != IDLE) && wordVld_s[bypassWord]) begin
      bypHitNext_s  = 1'b1;
      bypDataNext_s = words_r[bypassWord];
    end else begin
      bypHitNext_s  = 1'b0;
      bypDataNext_s = {WORD_W{1'b0}};
    end
  end
`endif

  // Fill/drain sequencing, fill and drain pointers, and the registered bypass.
  always_ff @(posedge CB) begin
    if (reset) begin
      state_r      <= IDLE;
      fillPtr_r    <= {SEL_W{1'b0}};
      fillCnt_r    <= {SEL_W{1'b0}};
      drainIdx_r   <= {SEL_W{1'b0}};
      bypassHit_r  <= 1'b0;
      bypassData_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (fillStart) begin
            state_r   <= FILL;
            fillPtr_r <= fillCritWord;
            fillCnt_r <= {SEL_W{1'b0}};
          end
        end
        FILL: begin
          if (fillAcc_s) begin
            fillPtr_r <= fillPtr_r + SEL_W'(1);
            fillCnt_r <= fillCnt_r + SEL_W'(1);
            if (fillLast_s) begin
              state_r    <= DRAIN;
              drainIdx_r <= {SEL_W{1'b0}};
            end
          end
        end
        DRAIN: begin
          if (drainLast_s) begin
            drainIdx_r <= {SEL_W{1'b0}};
            if (fillStart) begin
              state_r   <= FILL;
              fillPtr_r <= fillCritWord;
              fillCnt_r <= {SEL_W{1'b0}};
            end else begin
              state_r <= IDLE;
            end
          end else if (drainAcc_s) begin
            drainIdx_r <= drainIdx_r + SEL_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
      bypassHit_r  <= bypHitNext_s;
      bypassData_r <= bypDataNext_s;
    end
  end

  // Line storage with per-word fill-valid and per-byte store ownership.
  // Starting a line only clears the tracking bits; stale data stays hidden.
  always_ff @(posedge CB) begin
    if (reset) begin
      fillVld_r <= {WORDS_PER_LINE{1'b0}};
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        words_r[w] <= {WORD_W{1'b0}};
        owned_r[w] <= {BYTES{1'b0}};
      end
    end else if (lineStart_s) begin
      fillVld_r <= {WORDS_PER_LINE{1'b0}};
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        owned_r[w] <= {BYTES{1'b0}};
      end
    end else begin
      fillVld_r <= fillVld_r | fillWe_s;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        words_r[w] <= mergedWord_s[w];
        owned_r[w] <= mergedOwned_s[w];
      end
    end
  end

  assign storeAck     = storeAcc_s;
  assign bypassHit    = bypassHit_r;
  assign bypassData   = bypassData_r;
  assign busy         = (state_r != IDLE);
  assign drainVal     = (state_r == DRAIN);
  assign drainWordIdx = drainIdx_r;
  assign drainData    = drainVal ? words_r[drainIdx_r] : {WORD_W{1'b0}};

endmodule

// File: tb/tb_p405s_dcu_fill_buffer.sv
// Self-checking bench for p405s_dcu_fill_buffer (default geometry 8 x 32).
// Honours P405S_DCU_FB_STORE_FWD_EN the same way as the design build.
// Directed scenarios first, then randomized traffic against a line-level model.
module tb_p405s_dcu_fill_buffer;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int NB = W / 8;
  localparam int SW = 3;

`ifdef P405S_DCU_FB_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          CB = 1'b0;
  logic          reset;
  logic          fillStart;
  logic [SW-1:0] fillCritWord;
  logic          fillDataVal;
  logic [W-1:0]  fillData;
  logic          storeVal;
  logic [SW-1:0] storeWord;
  logic [NB-1:0] storeByteEn;
  logic [W-1:0]  storeData;
  logic          storeAck;
  logic          bypassReq;
  logic [SW-1:0] bypassWord;
  logic          bypassHit;
  logic [W-1:0]  bypassData;
  logic          drainVal;
  logic          drainRdy;
  logic [SW-1:0] drainWordIdx;
  logic [W-1:0]  drainData;
  logic          busy;

  p405s_dcu_fill_buffer #(.WORDS_PER_LINE(N), .WORD_W(W)) dut (
    .CB(CB), .reset(reset),
    .fillStart(fillStart), .fillCritWord(fillCritWord),
    .fillDataVal(fillDataVal), .fillData(fillData),
    .storeVal(storeVal), .storeWord(storeWord), .storeByteEn(storeByteEn),
    .storeData(storeData), .storeAck(storeAck),
    .bypassReq(bypassReq), .bypassWord(bypassWord),
    .bypassHit(bypassHit), .bypassData(bypassData),
    .drainVal(drainVal), .drainRdy(drainRdy),
    .drainWordIdx(drainWordIdx), .drainData(drainData), .busy(busy)
  );

  always #5 CB = ~CB;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 filling, 2 draining.
  int           mMode, mCrit, mCnt, mDrain;
  logic [W-1:0] mWord [N];
  logic [NB-1:0] mOwn [N];
  bit           mGot [N];
  logic         expHit;
  logic [W-1:0] expData;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] getByte(input logic [W-1:0] wd, input int b);
    logic [W-1:0] t;
    t = wd >> ((NB - 1 - b) * 8);
    return t[7:0];
  endfunction

  function automatic logic [W-1:0] setByte(input logic [W-1:0] wd, input int b, input logic [7:0] v);
    int sh;
    sh = (NB - 1 - b) * 8;
    return (wd & ~(W'(32'hFF) << sh)) | (W'(v) << sh);
  endfunction

  function automatic bit mValid(input int w);
    return mGot[w] || (mOwn[w] == {NB{1'b1}});
  endfunction

  task automatic modelClearLine();
    for (int w = 0; w < N; w++) begin
      mGot[w] = 1'b0;
      mOwn[w] = {NB{1'b0}};
    end
  endtask

  task automatic modelReset();
    mMode = 0; mCrit = 0; mCnt = 0; mDrain = 0;
    modelClearLine();
    for (int w = 0; w < N; w++) mWord[w] = {W{1'b0}};
    expHit = 1'b0; expData = {W{1'b0}};
  endtask

  task automatic modelLookup();
    int bw;
    bw = int'(bypassWord);
    expHit  = bypassReq && (mMode != 0) && mValid(bw);
    expData = expHit ? mWord[bw] : {W{1'b0}};
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic modelStep();
    int  fw, sw;
    bit  startNow;
    if (reset) begin
      modelReset();
      return;
    end
    if (!FWD) modelLookup();
    if (mMode == 1) begin
      if (storeVal) begin
        sw = int'(storeWord);
        for (int b = 0; b < NB; b++) begin
          if (storeByteEn[b]) begin
            mWord[sw]  = setByte(mWord[sw], b, getByte(storeData, b));
            mOwn[sw][b] = 1'b1;
          end
        end
      end
      if (fillDataVal) begin
        fw = (mCrit + mCnt) % N;
        for (int b = 0; b < NB; b++) begin
          if (!mOwn[fw][b]) mWord[fw] = setByte(mWord[fw], b, getByte(fillData, b));
        end
        mGot[fw] = 1'b1;
        mCnt++;
      end
    end
    if (FWD) modelLookup();
    startNow = 1'b0;
    case (mMode)
      0: if (fillStart) startNow = 1'b1;
      1: if (mCnt == N) begin mMode = 2; mDrain = 0; end
      2: if (drainRdy) begin
           if (mDrain == N - 1) begin
             mDrain = 0;
             if (fillStart) startNow = 1'b1;
             else mMode = 0;
           end else begin
             mDrain++;
           end
         end
      default: mMode = 0;
    endcase
    if (startNow) begin
      mMode = 1; mCrit = int'(fillCritWord); mCnt = 0;
      modelClearLine();
    end
  endtask

  task automatic clearIns();
    reset = 1'b0; fillStart = 1'b0; fillCritWord = '0; fillDataVal = 1'b0;
    fillData = '0; storeVal = 1'b0; storeWord = '0; storeByteEn = '0;
    storeData = '0; bypassReq = 1'b0; bypassWord = '0; drainRdy = 1'b0;
  endtask

  // One clock: check combinational outputs, step the model, check registered outputs.
  task automatic tick();
    #1;
    checkVal("busy", 64'(busy), 64'(mMode != 0));
    checkVal("drainVal", 64'(drainVal), 64'(mMode == 2));
    checkVal("drainIdx", 64'(drainWordIdx), 64'(mDrain));
    if (mMode == 2) checkVal("drainData", 64'(drainData), 64'(mWord[mDrain]));
    checkVal("storeAck", 64'(storeAck), 64'(storeVal && (mMode == 1)));
    modelStep();
    @(posedge CB);
    #1;
    checkVal("bypassHit", 64'(bypassHit), 64'(expHit));
    checkVal("bypassData", 64'(bypassData), 64'(expData));
  endtask

  // Words after the critical-word-first line below, indexed by word number.
  logic [W-1:0] t1Exp [N] = '{32'hA8, 32'hA9, 32'h11BBCCDD, 32'hAB,
                              32'hAC, 32'hA5, 32'hA6, 32'hA7};

  initial begin
    clearIns();
    reset = 1'b1; storeVal = 1'b1; bypassReq = 1'b1;
    repeat (2) @(posedge CB);
    #1;
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_bypassHit", 64'(bypassHit), 64'd0);
    checkVal("rst_bypassData", 64'(bypassData), 64'd0);
    checkVal("rst_drainVal", 64'(drainVal), 64'd0);
    checkVal("rst_drainIdx", 64'(drainWordIdx), 64'd0);
    checkVal("rst_drainData", 64'(drainData), 64'd0);
    checkVal("rst_storeAck", 64'(storeAck), 64'd0);
    modelReset();
    clearIns();
    bypassReq = 1'b1; bypassWord = 3'd1;
    tick();

    // Critical-word-first line starting at word 5; store owns byte 0 of word 2.
    clearIns(); fillStart = 1'b1; fillCritWord = 3'd5;
    tick();
    for (int k = 0; k < N; k++) begin
      clearIns();
      fillDataVal = 1'b1;
      fillData = (k == 5) ? 32'hAABBCCDD : 32'(32'hA5 + k);
      if (k == 0) begin
        storeVal = 1'b1; storeWord = 3'd2; storeByteEn = 4'b0001; storeData = 32'h11223344;
      end
      bypassReq = 1'b1; bypassWord = SW'(k);
      tick();
    end
    for (int w = 0; w < N; w++) begin
      clearIns(); bypassReq = 1'b1; bypassWord = SW'(w);
      tick();
      checkVal("cwf_hit", 64'(bypassHit), 64'd1);
      checkVal("cwf_data", 64'(bypassData), 64'(t1Exp[w]));
    end
    // Drain words 0..3, hold word 4 for three cycles, then finish.
    for (int k = 0; k < 4; k++) begin
      clearIns(); drainRdy = 1'b1;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      clearIns();
      tick();
      checkVal("bp_idx", 64'(drainWordIdx), 64'd4);
      checkVal("bp_data", 64'(drainData), 64'(32'hAC));
    end
    for (int k = 4; k < N - 1; k++) begin
      clearIns(); drainRdy = 1'b1;
      tick();
    end
    // Final drain accept with a new fillStart: straight back into FILL.
    clearIns(); drainRdy = 1'b1; fillStart = 1'b1; fillCritWord = 3'd0;
    tick();
    checkVal("b2b_busy", 64'(busy), 64'd1);
    checkVal("b2b_drainVal", 64'(drainVal), 64'd0);
    clearIns(); bypassReq = 1'b1; bypassWord = 3'd2;
    tick();
    checkVal("b2b_miss", 64'(bypassHit), 64'd0);

    // Fill words 0..2, then same-cycle fill + store (bytes 2,3) + bypass on word 3.
    for (int k = 0; k < 3; k++) begin
      clearIns(); fillDataVal = 1'b1; fillData = $urandom;
      tick();
    end
    clearIns();
    fillDataVal = 1'b1; fillData = 32'h01020304;
    storeVal = 1'b1; storeWord = 3'd3; storeByteEn = 4'b1100; storeData = 32'hFFFF0A0B;
    bypassReq = 1'b1; bypassWord = 3'd3;
    tick();
    checkVal("same_hit", 64'(bypassHit), 64'(FWD));
    checkVal("same_data", 64'(bypassData), FWD ? 64'(32'h01020A0B) : 64'd0);

    // Reset mid-fill abandons the line.
    clearIns(); reset = 1'b1; bypassReq = 1'b1; bypassWord = 3'd0;
    tick();
    checkVal("midrst_busy", 64'(busy), 64'd0);
    checkVal("midrst_hit", 64'(bypassHit), 64'd0);
    clearIns(); fillStart = 1'b1; fillCritWord = 3'd2;
    tick();
    checkVal("restart_busy", 64'(busy), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      fillStart    = ($urandom_range(0, 9) < 2);
      fillCritWord = SW'($urandom_range(0, N - 1));
      fillDataVal  = ($urandom_range(0, 9) < 7);
      fillData     = $urandom;
      storeVal     = ($urandom_range(0, 9) < 3);
      storeWord    = SW'($urandom_range(0, N - 1));
      storeByteEn  = NB'($urandom);
      storeData    = $urandom;
      bypassReq    = ($urandom_range(0, 9) < 7);
      bypassWord   = SW'($urandom_range(0, N - 1));
      drainRdy     = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p405s_dcu_fill_buffer.md
# p405s_dcu_fill_buffer

Parametrised DCU line fill buffer with critical-word-first fill tracking, store-byte merging, load bypass and array drain sequencing. Sits between the PLB read-data return path and the data cache array. Load hits on an in-flight line are serviced from the buffer before the line is written into the array. Generalises the fixed 8-word combinational bypass mux with per-word valid tracking, a fill/drain state machine and sticky store-byte ownership.

## Interface
Parameters:
- WORDS_PER_LINE, 8, words per cache line; power of two, 2..16
- WORD_W, 32, word width; multiple of 8
- Derived: BYTES = WORD_W/8, SEL_W = clog2(WORDS_PER_LINE)

Ports:
- CB  in  1  clock; one clock domain; all logic on rising edge
- reset  in  1  synchronous, active-high
- fillStart  in  1  begin a line fill; accepted only in IDLE
- fillCritWord  in  SEL_W  first word index returned; sampled with fillStart
- fillDataVal  in  1  one fill word present
- fillData  in  WORD_W  fill word
- storeVal  in  1  store to the in-flight line
- storeWord  in  SEL_W  store word index
- storeByteEn  in  BYTES  byte enables, bit 0 = byte 0 (MSB byte)
- storeData  in  WORD_W  store data
- storeAck  out  1  combinational: storeVal & state==FILL
- bypassReq  in  1  load lookup
- bypassWord  in  SEL_W  load word index
- bypassHit  out  1  registered: requested word fully valid
- bypassData  out  WORD_W  registered bypass word
- drainVal  out  1  drain word offered to array
- drainRdy  in  1  array accepts drain word
- drainWordIdx  out  SEL_W  index of offered word
- drainData  out  WORD_W  offered word
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE -> FILL on fillStart. Clears all word-valid and byte-owned bits. Loads fill pointer = fillCritWord and fill count = 0.
- FILL: each fillDataVal writes fillData to word[fillPtr]. Bytes already owned by a store are masked and keep store data. fillPtr increments modulo WORDS_PER_LINE (wrap 7 -> 0). Count increments.
- Last fill word accepted (count == WORDS_PER_LINE-1 with fillDataVal): FILL -> DRAIN on the next edge.
- Store in FILL: writes enabled bytes into word[storeWord] and sets their byte-owned bits.
- Fill and store to the same word in the same cycle: store bytes win; fill supplies the remaining bytes.
- Word-valid = fill received OR all byte-owned bits set.
- Stores outside FILL are not acknowledged and are dropped.
- bypassHit = bypassReq & word-valid[bypassWord]. bypassData = word contents; zero when bypassHit is 0.
- DRAIN: drainVal = 1. drainWordIdx starts at 0 and ascends; it advances on drainVal & drainRdy. After the last word is accepted, go to IDLE.
- fillStart in the same cycle as the last drain accept is accepted: DRAIN -> FILL directly.
- fillStart in FILL or DRAIN (except the case above) is ignored.
- fillDataVal in IDLE/DRAIN is ignored.
- bypassReq is serviced in all states; in IDLE it always misses.

## Timing
- Reset values: state IDLE, busy 0, bypassHit 0, bypassData 0, drainVal 0, drainWordIdx 0, drainData 0, storeAck 0. All valid/owned bits clear.
- Reset mid-fill or mid-drain abandons the line. The next cycle is IDLE.
- Bypass latency is 1: request at cycle t -> bypassHit/bypassData valid at t+1.
- drainData/drainWordIdx are combinational from the buffer and the drain index. They are stable while drainVal & !drainRdy.
- Minimum line turnaround: WORDS_PER_LINE fill cycles + 1 + WORDS_PER_LINE drain cycles.

## Configuration
- P405S_DCU_FB_STORE_FWD_EN defined: bypass at t+1 reflects writes accepted at t, so same-cycle fill and store data are forwarded.
- P405S_DCU_FB_STORE_FWD_EN undefined: bypass at t+1 reflects buffer state at the start of cycle t. A word written at t hits at the earliest for a request at t+1.

## Structure
- Package p405s_dcu_fb_pkg holds:
  - the state enum (IDLE, FILL, DRAIN)
  - clog2-derived width constants
  - the byte-lane helper function
- Sub-module p405s_dcu_fb_byte_merge:
  - per-word byte merge of fill data, store data, byte enables and owned mask
  - instantiated once per word

## Test plan
- Critical-word-first fill: fillCritWord=5, fill words 0xA5..0xAC on consecutive cycles. Require words stored at indices 5,6,7,0,1,2,3,4. Then DRAIN emits indices 0..7 in order with drainRdy=1.
- Store merge with ownership: during FILL, before word 2 arrives, store storeWord=2, storeByteEn=1000, storeData=0x11xxxxxx. Fill word 2 = 0xAABBCCDD. Require bypass of word 2 = 0x11BBCCDD, bypassHit=1.
- Same-cycle fill+store+bypass on word 3, with fill 0x01020304 and store enables 0011 data 0xxxxx0A0B:
  - With the macro: hit at t+1, data 0x01020A0B.
  - Without the macro: miss at t+1.
- Drain backpressure: drainRdy low for 3 cycles on word 4. Require drainWordIdx=4 and drainData held stable, then advance.
- Back-to-back lines: fillStart on the cycle of the final drain accept. Require FILL next cycle and all prior valid bits clear (bypass of any word misses).
- Reset mid-fill after 3 words. Require busy=0 and bypassHit=0 at t+1. A subsequent fillStart starts cleanly.
